mux_nto1_seq: RTL and testbench

MUX_NTO1_SEQ -- requirements
Module: mux_nto1_seq

---
 rtl/mux_nto1_seq.sv | 131 +++++++++++++
 tb/tb_mux_nto1_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_seq.sv
// Registered N-to-1 multiplexer with manual channel select and an automatic
// round-robin scan mode that holds each channel for DWELL enabled cycles.
module mux_nto1_seq #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int DWELL = 4,
  localparam int SELW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [CH*WIDTH-1:0] Data_in,
  input  logic [SELW-1:0]     Sel,
  input  logic                Mode,
  input  logic                En,
  output logic [WIDTH-1:0]    Out,
  output logic                Out_valid,
  output logic [SELW-1:0]     Cur_sel,
  output logic                Err
);

  localparam int CNTW = $clog2(DWELL + 1);
  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CUR_LAST   = SELW'(CH - 1);
  localparam logic [SELW:0]   SEL_LIM    = (SELW + 1)'(CH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  out_reg, out_next;
  logic              valid_reg, valid_next;
  logic [SELW-1:0]   cur_reg, cur_next;
  logic              err_reg, err_next;
  logic [CNTW-1:0]   cnt_reg, cnt_next;

  logic [WIDTH-1:0]  chan [CH];
  logic              sel_legal;
  logic [SELW-1:0]   scan_idx;
  logic [CNTW-1:0]   scan_cnt;
  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  scan_data;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      assign chan[gi] = Data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Widened compare so a power-of-two CH does not produce a constant result.
  assign sel_legal = ({1'b0, Sel} < SEL_LIM);

  // Channel the scan would land on this edge: entry point, hold, or advance.
  always_comb begin
    scan_idx = cur_reg;
    scan_cnt = cnt_reg + 1'b1;
    if (state_reg != SCAN) begin
      scan_idx = (state_reg == MANUAL && sel_legal) ? Sel : '0;
      scan_cnt = '0;
    end else if (cnt_reg == DWELL_LAST) begin
      scan_idx = (cur_reg == CUR_LAST) ? '0 : cur_reg + 1'b1;
      scan_cnt = '0;
    end
  end

  always_comb begin
    sel_data  = '0;
    scan_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (Sel == SELW'(k))
        sel_data = chan[k];
      if (scan_idx == SELW'(k))
        scan_data = chan[k];
    end
  end

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    valid_next = valid_reg;
    cur_next   = cur_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    if (En) begin
      if (Mode) begin
        state_next = SCAN;
        cur_next   = scan_idx;
        cnt_next   = scan_cnt;
        out_next   = scan_data;
        valid_next = 1'b1;
      end else begin
        state_next = MANUAL;
        cnt_next   = '0;
        if (sel_legal) begin
          out_next   = sel_data;
          cur_next   = Sel;
          valid_next = 1'b1;
        end else begin
          valid_next = 1'b0;
          err_next   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      valid_reg <= 1'b0;
      cur_reg   <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
      cur_reg   <= cur_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign Out       = out_reg;
  assign Out_valid = valid_reg;
  assign Cur_sel   = cur_reg;
  assign Err       = err_reg;

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Directed bench: instance a (CH=4, DWELL=2) for manual/scan/freeze/reset,
// instance b (CH=3, DWELL=3) for illegal selects and non-power-of-two wrap.
module tb_mux_nto1_seq;

  logic        Clk = 1'b0;
  logic        Rst_n;

  logic [31:0] a_data;
  logic [1:0]  a_sel;
  logic        a_mode, a_en;
  logic [7:0]  a_out;
  logic        a_valid, a_err;
  logic [1:0]  a_cur;

  logic [23:0] b_data;
  logic [1:0]  b_sel;
  logic        b_mode, b_en;
  logic [7:0]  b_out;
  logic        b_valid, b_err;
  logic [1:0]  b_cur;

  int compared   = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  mux_nto1_seq #(.WIDTH(8), .CH(4), .DWELL(2)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .Data_in(a_data), .Sel(a_sel), .Mode(a_mode),
    .En(a_en), .Out(a_out), .Out_valid(a_valid), .Cur_sel(a_cur), .Err(a_err)
  );

  mux_nto1_seq #(.WIDTH(8), .CH(3), .DWELL(3)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .Data_in(b_data), .Sel(b_sel), .Mode(b_mode),
    .En(b_en), .Out(b_out), .Out_valid(b_valid), .Cur_sel(b_cur), .Err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] out, input logic valid,
                       input logic [1:0] cur, input logic err);
    chk({tag, ".out"}, 32'(a_out), 32'(out));
    chk({tag, ".valid"}, 32'(a_valid), 32'(valid));
    chk({tag, ".cur"}, 32'(a_cur), 32'(cur));
    chk({tag, ".err"}, 32'(a_err), 32'(err));
    $display("a %s: out=%02h valid=%0b cur=%0d err=%0b", tag, a_out, a_valid, a_cur, a_err);
  endtask

  task automatic chk_b(input string tag, input logic [7:0] out, input logic valid,
                       input logic [1:0] cur, input logic err);
    chk({tag, ".out"}, 32'(b_out), 32'(out));
    chk({tag, ".valid"}, 32'(b_valid), 32'(valid));
    chk({tag, ".cur"}, 32'(b_cur), 32'(cur));
    chk({tag, ".err"}, 32'(b_err), 32'(err));
    $display("b %s: out=%02h valid=%0b cur=%0d err=%0b", tag, b_out, b_valid, b_cur, b_err);
  endtask

  // One active edge, then sample on the following falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    logic [7:0] a_exp [4];
    logic [1:0] scan_seq [10];
    a_exp = '{8'hA1, 8'h00, 8'hC3, 8'h0F};
    scan_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

    Rst_n  = 1'b0;
    a_data = {8'h0F, 8'hC3, 8'h00, 8'hA1};
    a_sel  = 2'd0; a_mode = 1'b0; a_en = 1'b1;
    b_data = {8'h33, 8'h22, 8'h11};
    b_sel  = 2'd0; b_mode = 1'b0; b_en = 1'b1;

    tick();
    tick();
    chk_a("reset", 8'h00, 1'b0, 2'd0, 1'b0);

    // Released reset with En low: outputs keep reset values.
    Rst_n = 1'b1;
    a_en  = 1'b0;
    tick();
    chk_a("post_rst_en0", 8'h00, 1'b0, 2'd0, 1'b0);
    a_en = 1'b1;

    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      tick();
      chk_a($sformatf("man_sel%0d_e1", s), a_exp[s], 1'b1, 2'(s), 1'b0);
      tick();
      chk_a($sformatf("man_sel%0d_e2", s), a_exp[s], 1'b1, 2'(s), 1'b0);
    end

    // Manual sel 2 then scan: starts at 2, holds two edges, then 3, wraps to 0.
    a_sel = 2'd2;
    tick();
    chk_a("m2s_pre", 8'hC3, 1'b1, 2'd2, 1'b0);
    a_mode = 1'b1;
    tick();
    chk_a("m2s_entry", 8'hC3, 1'b1, 2'd2, 1'b0);
    tick();
    chk_a("m2s_hold2", 8'hC3, 1'b1, 2'd2, 1'b0);
    tick();
    chk_a("m2s_ch3a", 8'h0F, 1'b1, 2'd3, 1'b0);
    tick();
    chk_a("m2s_ch3b", 8'h0F, 1'b1, 2'd3, 1'b0);
    tick();
    chk_a("m2s_wrap0", 8'hA1, 1'b1, 2'd0, 1'b0);
    a_data[7:0] = 8'h5A;
    tick();
    chk_a("live_data", 8'h5A, 1'b1, 2'd0, 1'b0);
    a_data[7:0] = 8'hA1;

    a_mode = 1'b0;
    a_sel  = 2'd1;
    tick();
    chk_a("s2m_sel1", 8'h00, 1'b1, 2'd1, 1'b0);

    // Scan again from sel 1, then reset between edges mid-scan.
    a_mode = 1'b1;
    tick();
    chk_a("scan_from1", 8'h00, 1'b1, 2'd1, 1'b0);
    tick();
    tick();
    chk_a("scan_ch2", 8'hC3, 1'b1, 2'd2, 1'b0);
    #2 Rst_n = 1'b0;
    #1 chk_a("async_rst", 8'h00, 1'b0, 2'd0, 1'b0);
    #1 Rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk_a($sformatf("scan_seq%0d", i), a_exp[scan_seq[i]], 1'b1, scan_seq[i], 1'b0);
    end
    tick();
    chk_a("scan_ch1_first", 8'h00, 1'b1, 2'd1, 1'b0);

    // Freeze for five cycles; live data change must not reach Out while frozen.
    a_en = 1'b0;
    a_data[15:8] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a($sformatf("freeze%0d", i), 8'h00, 1'b1, 2'd1, 1'b0);
    end
    a_en = 1'b1;
    tick();
    chk_a("resume_hold", 8'h77, 1'b1, 2'd1, 1'b0);
    tick();
    chk_a("resume_adv", 8'hC3, 1'b1, 2'd2, 1'b0);

    // Instance b: CH=3, illegal select 3.
    b_sel = 2'd1;
    tick();
    chk_b("b_sel1", 8'h22, 1'b1, 2'd1, 1'b0);
    b_sel = 2'd3;
    tick();
    chk_b("b_ill_e1", 8'h22, 1'b0, 2'd1, 1'b1);
    tick();
    chk_b("b_ill_e2", 8'h22, 1'b0, 2'd1, 1'b1);
    b_en = 1'b0;
    tick();
    chk_b("b_ill_en0", 8'h22, 1'b0, 2'd1, 1'b0);
    b_en = 1'b1;
    b_sel = 2'd2;
    tick();
    chk_b("b_sel2", 8'h33, 1'b1, 2'd2, 1'b0);

    // Scan entry with illegal select starts at 0; wraps 2 -> 0 with DWELL=3.
    b_sel  = 2'd3;
    b_mode = 1'b1;
    tick();
    chk_b("b_scan0a", 8'h11, 1'b1, 2'd0, 1'b0);
    tick();
    tick();
    chk_b("b_scan0c", 8'h11, 1'b1, 2'd0, 1'b0);
    tick();
    chk_b("b_scan1a", 8'h22, 1'b1, 2'd1, 1'b0);
    tick();
    tick();
    tick();
    chk_b("b_scan2a", 8'h33, 1'b1, 2'd2, 1'b0);
    tick();
    tick();
    tick();
    chk_b("b_wrap0", 8'h11, 1'b1, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
